// File: rtl/gpio_pwm_pkg.sv
// Shared constants and types for the GPIO PWM generator / capture pair.
package gpio_pwm_pkg;

    localparam int unsigned CNT_W_DEF  = 12;
    localparam int unsigned PRESCALE_W = 20;

    // Divider stop values: a tick fires when the divider reaches the entry, so /N stores N-1.
    localparam logic [PRESCALE_W-1:0] PRESCALE_STOP [8] = '{
        20'd0, 20'd1, 20'd9, 20'd99, 20'd999, 20'd9999, 20'd99999, 20'd999999
    };

    typedef enum logic [1:0] {
        MEAS_OFF     = 2'd0,
        MEAS_ONESHOT = 2'd1,
        MEAS_CONT    = 2'd2,
        MEAS_RSVD    = 2'd3
    } meas_ctrl_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_RISE = 3'd1,
        ST_MEAS_HIGH = 3'd2,
        ST_MEAS_LOW  = 3'd3,
        ST_DONE      = 3'd4
    } meas_state_e;

    function automatic logic ctrl_active(input logic [1:0] ctrl);
        return (ctrl == MEAS_ONESHOT) || (ctrl == MEAS_CONT);
    endfunction

endpackage

// File: rtl/gpio_prescale.sv
// Free-running prescale tick generator; clear_i restarts the divider at 0.
module gpio_prescale
    import gpio_pwm_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [2:0] prescale_i,
    input  logic       clear_i,
    output logic       tick_o
);

    logic [PRESCALE_W-1:0] div_q;
    logic [PRESCALE_W-1:0] div_d;
    logic [PRESCALE_W-1:0] stop;

    assign stop = PRESCALE_STOP[prescale_i];

    always_comb begin
        div_d = div_q + 1'b1;
        if (clear_i || (div_q >= stop)) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick_o = (stop == '0) || (div_q == stop);

endmodule

// File: rtl/gpio_pwm_meas.sv
// PWM capture: measures high/low time of an input pin in prescaled ticks.
// Optional build macro GPIO_PWM_MEAS_TIMEOUT_EN publishes on counter saturation.
module gpio_pwm_meas
    import gpio_pwm_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_pin_in,
    input  logic [1:0]       meas_ctrl,
    input  logic [2:0]       meas_prescale,
    output logic [CNT_W-1:0] meas_hout,
    output logic [CNT_W-1:0] meas_lout,
    output logic             meas_valid,
    output logic             meas_done,
    output logic             meas_ovfl
);

`ifdef GPIO_PWM_MEAS_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]             ctrl_p1_q, ctrl_p2_q;
    logic [2:0]             pre_p1_q, pre_p2_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    meas_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       hold_q, hold_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_W-1:0]       hout_q, hout_d;
    logic [CNT_W-1:0]       lout_q, lout_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic                   movfl_q, movfl_d;

    logic             pin_s, rise, fall, restart, oneshot, tick, sat;
    logic [CNT_W-1:0] cnt_inc;

    assign pin_s   = sync_q[SYNC_STAGES-1];
    assign rise    = pin_s & ~hist_q;
    assign fall    = ~pin_s & hist_q;
    assign restart = (ctrl_p1_q != ctrl_p2_q) || (pre_p1_q != pre_p2_q);
    assign oneshot = (ctrl_p1_q == MEAS_ONESHOT);

    gpio_prescale u_prescale (
        .clk_i      (clk),
        .reset_i    (reset),
        .prescale_i (pre_p1_q),
        .clear_i    (state_q == ST_IDLE),
        .tick_o     (tick)
    );

    // Count including this cycle's tick, saturating; edge cycles use it so a coincident tick joins the ending phase.
    assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(tick);
    assign sat     = (cnt_inc == CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        ovf_d   = ovf_q;
        hout_d  = hout_q;
        lout_d  = lout_q;
        valid_d = 1'b0;
        movfl_d = movfl_q;
        if (restart) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    ovf_d = 1'b0;
                    if (ctrl_active(ctrl_p1_q)) begin
                        state_d = ST_WAIT_RISE;
                    end
                end
                ST_WAIT_RISE: begin
                    if (rise) begin
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = ST_MEAS_HIGH;
                    end
                end
                ST_MEAS_HIGH: begin
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | sat;
                    if (fall) begin
                        hold_d  = cnt_inc;
                        cnt_d   = '0;
                        state_d = ST_MEAS_LOW;
                    end else if (TIMEOUT_EN && sat) begin
                        hout_d  = CNT_MAX;
                        lout_d  = '0;
                        valid_d = 1'b1;
                        movfl_d = 1'b1;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = oneshot ? ST_DONE : ST_WAIT_RISE;
                    end
                end
                ST_MEAS_LOW: begin
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | sat;
                    if (rise) begin
                        hout_d  = hold_q;
                        lout_d  = cnt_inc;
                        valid_d = 1'b1;
                        movfl_d = ovf_q | sat;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = oneshot ? ST_DONE : ST_MEAS_HIGH;
                    end else if (TIMEOUT_EN && sat) begin
                        hout_d  = hold_q;
                        lout_d  = CNT_MAX;
                        valid_d = 1'b1;
                        movfl_d = 1'b1;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = oneshot ? ST_DONE : ST_WAIT_RISE;
                    end
                end
                ST_DONE: begin
                    if (ctrl_p1_q == MEAS_OFF) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_p1_q <= '0;
            ctrl_p2_q <= '0;
            pre_p1_q  <= '0;
            pre_p2_q  <= '0;
            sync_q    <= '0;
            hist_q    <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            ovf_q     <= 1'b0;
            hout_q    <= '0;
            lout_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            movfl_q   <= 1'b0;
        end else begin
            ctrl_p1_q <= meas_ctrl;
            ctrl_p2_q <= ctrl_p1_q;
            pre_p1_q  <= meas_prescale;
            pre_p2_q  <= pre_p1_q;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pwm_pin_in};
            hist_q    <= pin_s;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            ovf_q     <= ovf_d;
            hout_q    <= hout_d;
            lout_q    <= lout_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            movfl_q   <= movfl_d;
        end
    end

    assign meas_hout  = hout_q;
    assign meas_lout  = lout_q;
    assign meas_valid = valid_q;
    assign meas_done  = done_q;
    assign meas_ovfl  = movfl_q;

endmodule

// File: tb/tb_gpio_pwm_meas.sv
// Self-checking bench for gpio_pwm_meas (vector table, corner sequences, random periods).
module tb_gpio_pwm_meas;

    logic        clk = 1'b0;
    logic        reset;
    logic        pwm_pin_in;
    logic [1:0]  meas_ctrl;
    logic [2:0]  meas_prescale;
    logic [11:0] meas_hout;
    logic [11:0] meas_lout;
    logic        meas_valid;
    logic        meas_done;
    logic        meas_ovfl;

    gpio_pwm_meas #(.CNT_W(12), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .pwm_pin_in    (pwm_pin_in),
        .meas_ctrl     (meas_ctrl),
        .meas_prescale (meas_prescale),
        .meas_hout     (meas_hout),
        .meas_lout     (meas_lout),
        .meas_valid    (meas_valid),
        .meas_done     (meas_done),
        .meas_ovfl     (meas_ovfl)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int l;
        int o;
    } cap_t;

    typedef struct {
        int pre;
        int ctrl;
        int hi;
        int lo;
        int eh;
        int el;
        int eo;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    cap_t cap_q[$];
    cap_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Hold the pin at lvl for n clocks, recording every published result.
    task automatic drive(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_pin_in = lvl;
            @(posedge clk);
            #1;
            if (meas_valid === 1'b1) begin
                cap_q.push_back('{int'(meas_hout), int'(meas_lout), int'(meas_ovfl)});
            end
        end
    endtask

    task automatic arm(input int pre, input int ctrl);
        meas_ctrl = 2'd0;
        drive(1'b0, 5);
        meas_prescale = 3'(pre);
        meas_ctrl     = 2'(ctrl);
        drive(1'b0, 10);
        cap_q.delete();
    endtask

    vec_t vt[9];

    initial begin
        vt[0] = '{0, 2, 5, 3, 5, 3, 0};
        vt[1] = '{2, 1, 200, 100, 20, 10, 0};
`ifdef GPIO_PWM_MEAS_TIMEOUT_EN
        vt[2] = '{0, 2, 5000, 10, 4095, 0, 1};
`else
        vt[2] = '{0, 2, 5000, 10, 4095, 10, 1};
`endif
        vt[3] = '{1, 2, 6, 10, 3, 5, 0};
        vt[4] = '{3, 2, 300, 500, 3, 5, 0};
        vt[5] = '{0, 2, 1, 1, 1, 1, 0};
        vt[6] = '{0, 2, 4094, 2, 4094, 2, 0};
        vt[7] = '{0, 2, 4095, 2, 4095, 2, 1};
        vt[8] = '{0, 1, 7, 9, 7, 9, 0};

        reset         = 1'b1;
        pwm_pin_in    = 1'b0;
        meas_ctrl     = 2'd2;
        meas_prescale = 3'd0;
        for (int i = 0; i < 4; i++) begin
            pwm_pin_in = i[0];
            @(posedge clk);
            #1;
        end
        chk("rst_hout", meas_hout, 0);
        chk("rst_lout", meas_lout, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_done", meas_done, 0);
        chk("rst_ovfl", meas_ovfl, 0);
        reset = 1'b0;

        for (int v = 0; v < 9; v++) begin
            arm(vt[v].pre, vt[v].ctrl);
            drive(1'b1, vt[v].hi);
            drive(1'b0, vt[v].lo);
            drive(1'b1, 8);
            drive(1'b0, 8);
            drive(1'b1, 8);
            drive(1'b0, 4);
            chk($sformatf("vec%0d_npub", v), cap_q.size(), (vt[v].ctrl == 1) ? 1 : 2);
            if (cap_q.size() >= 1) begin
                chk($sformatf("vec%0d_hout", v), cap_q[0].h, vt[v].eh);
                chk($sformatf("vec%0d_lout", v), cap_q[0].l, vt[v].el);
                chk($sformatf("vec%0d_ovfl", v), cap_q[0].o, vt[v].eo);
            end
            if (vt[v].ctrl == 2 && vt[v].pre == 0 && cap_q.size() >= 2) begin
                chk($sformatf("vec%0d_next_h", v), cap_q[1].h, 8);
                chk($sformatf("vec%0d_next_l", v), cap_q[1].l, 8);
                chk($sformatf("vec%0d_next_ovfl", v), cap_q[1].o, 0);
            end
            if (vt[v].ctrl == 1) begin
                chk($sformatf("vec%0d_done", v), meas_done, 1);
                meas_ctrl = 2'd0;
                drive(1'b0, 1);
                chk($sformatf("vec%0d_done_hold", v), meas_done, 1);
                drive(1'b0, 1);
                chk($sformatf("vec%0d_done_clr", v), meas_done, 0);
                chk($sformatf("vec%0d_result_hold", v), meas_hout, vt[v].eh);
            end else begin
                chk($sformatf("vec%0d_done", v), meas_done, 0);
            end
        end

        // Random periods: expected result is simply duration / tick period.
        for (int r = 0; r < 2; r++) begin
            int div;
            div = (r == 0) ? 1 : 2;
            arm(r, 2);
            exp_q.delete();
            for (int i = 0; i < 20; i++) begin
                int hi, lo;
                hi = div * int'($urandom_range(1, 15));
                lo = div * int'($urandom_range(1, 15));
                drive(1'b1, hi);
                drive(1'b0, lo);
                exp_q.push_back('{hi / div, lo / div, 0});
            end
            drive(1'b1, 4);
            drive(1'b0, 6);
            chk($sformatf("rand%0d_npub", r), cap_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
                chk($sformatf("rand%0d_%0d_h", r, i), cap_q[i].h, exp_q[i].h);
                chk($sformatf("rand%0d_%0d_l", r, i), cap_q[i].l, exp_q[i].l);
                chk($sformatf("rand%0d_%0d_o", r, i), cap_q[i].o, exp_q[i].o);
            end
        end

        // Prescale change while measuring low: broken period is dropped.
        arm(0, 2);
        drive(1'b1, 5);
        drive(1'b0, 3);
        drive(1'b1, 5);
        cap_q.delete();
        drive(1'b0, 3);
        meas_prescale = 3'd1;
        drive(1'b0, 5);
        drive(1'b1, 6);
        drive(1'b0, 4);
        drive(1'b1, 6);
        drive(1'b0, 10);
        chk("presc_chg_npub", cap_q.size(), 1);
        if (cap_q.size() >= 1) begin
            chk("presc_chg_h", cap_q[0].h, 3);
            chk("presc_chg_l", cap_q[0].l, 2);
        end

        // Reset in the middle of a high phase.
        arm(0, 2);
        drive(1'b1, 5);
        drive(1'b0, 3);
        drive(1'b1, 5);
        drive(1'b1, 6);
        chk("pre_rst_hout", meas_hout, 5);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_hout", meas_hout, 0);
        chk("midrst_lout", meas_lout, 0);
        chk("midrst_valid", meas_valid, 0);
        chk("midrst_done", meas_done, 0);
        chk("midrst_ovfl", meas_ovfl, 0);
        reset = 1'b0;
        cap_q.delete();
        drive(1'b0, 10);
        drive(1'b1, 5);
        drive(1'b0, 3);
        drive(1'b1, 5);
        drive(1'b0, 6);
        chk("postrst_npub", cap_q.size(), 1);
        if (cap_q.size() >= 1) begin
            chk("postrst_h", cap_q[0].h, 5);
            chk("postrst_l", cap_q[0].l, 3);
        end

        // Pin stuck high.
        arm(0, 2);
        drive(1'b1, 4200);
`ifdef GPIO_PWM_MEAS_TIMEOUT_EN
        chk("stuck_npub", cap_q.size(), 1);
        if (cap_q.size() >= 1) begin
            chk("stuck_h", cap_q[0].h, 4095);
            chk("stuck_l", cap_q[0].l, 0);
            chk("stuck_o", cap_q[0].o, 1);
        end
        chk("stuck_ovfl_hold", meas_ovfl, 1);
`else
        chk("stuck_npub", cap_q.size(), 0);
        chk("stuck_ovfl_hold", meas_ovfl, 0);
        chk("stuck_hout_hold", meas_hout, 5);
`endif
        drive(1'b0, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_pwm_meas.md
Name: gpio_pwm_meas

Overview:
PWM capture block for the GPIO design, the receive-side counterpart to the GPIO PWM generator. It measures high time and low time of an input pin in prescaled ticks, using the same prescale encoding as the generator. Results use the generator's hout/lout units, so a loopback reproduces the programmed values. It sits between a GPIO input pin and the GPIO register file.

Parameters:
CNT_W, 12, width of high/low tick counters and result outputs
SYNC_STAGES, 2, flops in the pin synchronizer (min 2)

Ports:
clk  in  1  design clock
reset  in  1  synchronous, active-high reset
pwm_pin_in  in  1  asynchronous input pin
meas_ctrl  in  2  0=off, 1=one-shot, 2=continuous, 3=reserved (acts as 0)
meas_prescale  in  3  tick select: 0=every clk, 1=/2, 2=/10, 3=/100, 4=/1e3, 5=/1e4, 6=/1e5, 7=/1e6
meas_hout  out  CNT_W  last captured high time, ticks
meas_lout  out  CNT_W  last captured low time, ticks
meas_valid  out  1  one-clk pulse when meas_hout/meas_lout update
meas_done  out  1  one-shot complete, held until meas_ctrl=0
meas_ovfl  out  1  set with meas_valid if either count saturated in that period

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - All outputs go to 0, counters go to 0, FSM goes to IDLE, synchronizer flops go to 0.
- Inputs:
  - meas_ctrl and meas_prescale are registered once (_p1).
  - Any change of either _p1 value forces FSM to IDLE for one clk, then WAIT_RISE. This restart discards the in-progress count.
- Synchronizer and edge detect:
  - SYNC_STAGES flops, then one history flop.
  - Edge is detected SYNC_STAGES+1 clks after the pin transition.
- Prescaler:
  - Free-running divider from the prescale_p1 table, emitting a 1-clk tick.
  - The divider restarts at 0 whenever FSM is in IDLE.
  - prescale 0 means tick is constantly 1.
- FSM states: IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW, DONE.
  - IDLE: to WAIT_RISE when ctrl_p1 is 1 or 2.
  - WAIT_RISE: on rise, clear cnt and go to MEAS_HIGH. This discards the partial first high.
  - MEAS_HIGH: each tick, cnt++. On fall, hold_h = cnt+tick, clear cnt, go to MEAS_LOW.
  - MEAS_LOW: each tick, cnt++. On rise, publish meas_hout=hold_h and meas_lout=cnt+tick.
    - meas_valid pulses 1 clk, registered, in the clk after the edge-detect clk.
    - Continuous mode: go to MEAS_HIGH with cnt=0.
    - One-shot mode: go to DONE.
  - DONE: meas_done=1, outputs hold. Go to IDLE when ctrl_p1=0, which clears meas_done.
- Tick coincident with an edge: the tick counts toward the ending phase.
- Arithmetic: cnt saturates at 2^CNT_W-1, never wraps. A saturation flag is latched per period and presented on meas_ovfl with meas_valid. meas_ovfl holds until the next publish.
- Pin stuck (no edge): the FSM waits indefinitely unless the optional feature is compiled in.
- Results hold between publishes. ctrl=0 does not clear meas_hout/meas_lout.

Optional Feature:
GPIO_PWM_MEAS_TIMEOUT_EN:
- Defined:
  - Saturation reached in MEAS_HIGH or MEAS_LOW publishes immediately with meas_ovfl=1 and meas_valid pulsed.
  - Stuck phase reports all-ones. The unmeasured phase reports 0 (MEAS_HIGH) or hold_h (MEAS_LOW).
  - FSM then goes to WAIT_RISE (continuous) or DONE (one-shot).
- Undefined: no timeout; counts stay saturated until an edge arrives.

Decomposition:
- Shared package gpio_pwm_pkg contains:
  - prescale stop-value table (8 x 20-bit)
  - meas_ctrl codes
  - FSM state enum
  - CNT_W default
- Natural sub-module: gpio_prescale, a tick generator (prescale_p1 and clear in, tick out).
  - Reusable later by the generator.

Test Plan:
- prescale=0, ctrl=2, pin 5 clk high / 3 clk low repeating -> every 8 clks meas_valid=1, hout=5, lout=3, ovfl=0.
- prescale=2 (/10), ctrl=1, pin 200 clk high / 100 clk low -> one meas_valid, hout=20, lout=10, done=1; done clears 2 clks after ctrl=0.
- prescale=0, ctrl=2, pin high 5000 clks then low 10 -> hout=4095, lout=10, ovfl=1. Next normal period gives ovfl=0.
- Change prescale mid MEAS_LOW -> no meas_valid for the broken period; next full period is correct.
- reset asserted during MEAS_HIGH -> next clk all outputs 0, FSM IDLE; after release, first publish only after a full rise-fall-rise.
- With GPIO_PWM_MEAS_TIMEOUT_EN, prescale=0, pin held high -> meas_valid at saturation, hout=4095, lout=0, ovfl=1; without the macro -> no meas_valid.
